nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_pkg.sv | 17 +
 rtl/ripple_carry_adder_4bit.sv | 21 ++
 rtl/nibble_serial_adder.sv | 144 ++++++++++++++
 tb/tb_nibble_serial_adder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_pkg.sv
// Shared constants, FSM state type and counter sizing for the nibble-serial adder.
package nibble_serial_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Nibble counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/ripple_carry_adder_4bit.sv
// 4-bit ripple carry adder: the single-nibble datapath of the serial adder.
module ripple_carry_adder_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] sum,
  output logic       Cout
);

  always_comb begin
    logic w_c;
    w_c = Cin;
    sum = '0;
    for (int i = 0; i < 4; i++) begin
      sum[i] = A[i] ^ B[i] ^ w_c;
      w_c    = (A[i] & B[i]) | (w_c & (A[i] ^ B[i]));
    end
    Cout = w_c;
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder, one nibble per clock through a 4-bit ripple adder.
// Optional signed-overflow output enabled by NIBBLE_SERIAL_ADDER_OVF_EN.
module nibble_serial_adder
  import nibble_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             Cout
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned CntW    = cnt_width(NIBBLES);
  localparam logic [CntW-1:0] LastCnt = CntW'(NIBBLES - 1);

  state_e            r_state, w_state_d;
  logic [WIDTH-1:0]  r_a, w_a_d;
  logic [WIDTH-1:0]  r_b, w_b_d;
  logic [WIDTH-1:0]  r_psum, w_psum_d;
  logic [WIDTH-1:0]  r_sum, w_sum_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic              r_carry, w_carry_d;
  logic              r_cout, w_cout_d;

  logic [NIBBLE_W-1:0] w_add_sum;
  logic                w_add_cout;

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  // Operand sign bits are shifted out of r_a/r_b, so keep them separately.
  logic r_a_msb, w_a_msb_d;
  logic r_b_msb, w_b_msb_d;
  logic r_ovf, w_ovf_d;
`endif

  ripple_carry_adder_4bit u_rca (
    .A    (r_a[NIBBLE_W-1:0]),
    .B    (r_b[NIBBLE_W-1:0]),
    .Cin  (r_carry),
    .sum  (w_add_sum),
    .Cout (w_add_cout)
  );

  always_comb begin
    w_state_d = r_state;
    w_a_d     = r_a;
    w_b_d     = r_b;
    w_psum_d  = r_psum;
    w_sum_d   = r_sum;
    w_cnt_d   = r_cnt;
    w_carry_d = r_carry;
    w_cout_d  = r_cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    w_a_msb_d = r_a_msb;
    w_b_msb_d = r_b_msb;
    w_ovf_d   = r_ovf;
`endif
    unique case (r_state)
      StIdle, StDone: begin
        w_state_d = StIdle;
        if (start) begin
          w_state_d = StRun;
          w_a_d     = A;
          w_b_d     = B;
          w_carry_d = Cin;
          w_psum_d  = '0;
          w_cnt_d   = '0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
          w_a_msb_d = A[WIDTH-1];
          w_b_msb_d = B[WIDTH-1];
`endif
        end
      end
      StRun: begin
        w_a_d     = r_a >> NIBBLE_W;
        w_b_d     = r_b >> NIBBLE_W;
        w_carry_d = w_add_cout;
        w_psum_d  = {w_add_sum, r_psum[WIDTH-1:NIBBLE_W]};
        w_cnt_d   = r_cnt + CntW'(1);
        if (r_cnt == LastCnt) begin
          w_state_d = StDone;
          w_sum_d   = w_psum_d;
          w_cout_d  = w_add_cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
          w_ovf_d   = (r_a_msb == r_b_msb) && (w_add_sum[NIBBLE_W-1] != r_a_msb);
`endif
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_psum  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_d;
      r_a     <= w_a_d;
      r_b     <= w_b_d;
      r_psum  <= w_psum_d;
      r_sum   <= w_sum_d;
      r_cnt   <= w_cnt_d;
      r_carry <= w_carry_d;
      r_cout  <= w_cout_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      r_a_msb <= w_a_msb_d;
      r_b_msb <= w_b_msb_d;
      r_ovf   <= w_ovf_d;
`endif
    end
  end

  assign busy = (r_state == StRun);
  assign done = (r_state == StDone);
  assign sum  = r_sum;
  assign Cout = r_cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed, table-driven bench for nibble_serial_adder (WIDTH=16).
// Checks ovf as well when NIBBLE_SERIAL_ADDER_OVF_EN is defined.
module tb_nibble_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        Cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic        ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .Cout  (Cout)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Start is sampled on the edge between the two negedges; operands are then scrambled.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic c);
    @(negedge clk);
    A = a; B = b; Cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = ~a; B = ~b; Cin = ~c;
  endtask

  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (!done && lat < 20) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
  endtask

  initial begin
    int lat, bc, pulses;
    logic hold_ok;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[4] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{16'h1111, 16'h2222, 1'b1, 16'h3334, 1'b0, 1'b0};
    vecs[8] = '{16'h9ABC, 16'h6544, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[9] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    repeat (2) @(negedge clk);
    check_val("reset busy", busy, 0);
    check_val("reset done", done, 0);
    check_val("reset sum", sum, 0);
    check_val("reset cout", Cout, 0);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    check_val("reset ovf", ovf, 0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_done(lat, bc);
      check_val($sformatf("v%0d latency", i), lat, 4);
      check_val($sformatf("v%0d busy cycles", i), bc, 4);
      check_val($sformatf("v%0d busy at done", i), busy, 0);
      check_val($sformatf("v%0d sum", i), sum, vecs[i].exp_sum);
      check_val($sformatf("v%0d cout", i), Cout, vecs[i].exp_cout);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      check_val($sformatf("v%0d ovf", i), ovf, vecs[i].exp_ovf);
`endif
      @(negedge clk);
      check_val($sformatf("v%0d done width", i), done, 0);
      check_val($sformatf("v%0d sum hold", i), sum, vecs[i].exp_sum);
    end

    // Second start during RUN must be dropped.
    start_op(16'h00FF, 16'h0001, 1'b0);
    @(negedge clk);
    A = 16'hAAAA; B = 16'h5555; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    check_val("ignored latency", lat, 2);
    check_val("ignored sum", sum, 16'h0100);
    check_val("ignored cout", Cout, 0);
    count_done(10, pulses);
    check_val("ignored extra done", pulses, 0);

    // Back-to-back: new start in the DONE cycle.
    start_op(16'h1234, 16'h4321, 1'b0);
    wait_done(lat, bc);
    check_val("b2b first sum", sum, 16'h5555);
    A = 16'h8000; B = 16'h8000; Cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    hold_ok = 1'b1;
    while (!done && lat < 20) begin
      if (sum !== 16'h5555) hold_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check_val("b2b latency", lat, 4);
    check_val("b2b hold", hold_ok, 1);
    check_val("b2b sum", sum, 16'h0000);
    check_val("b2b cout", Cout, 1);

    // Reset mid-RUN after a completion that left sum nonzero.
    start_op(16'h0F0F, 16'h00F1, 1'b0);
    wait_done(lat, bc);
    start_op(16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    check_val("pre-reset busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_val("mid reset busy", busy, 0);
    check_val("mid reset done", done, 0);
    check_val("mid reset sum", sum, 0);
    check_val("mid reset cout", Cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    count_done(10, pulses);
    check_val("post reset done", pulses, 0);
    check_val("post reset busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
